// File: rtl/uart_tx_peripheral.sv
// Bridge-attached UART transmitter: word register interface, one-entry hold buffer,
// 8N1 serialiser with a per-frame latched bit divisor and a maskable level IRQ.
module uart_tx_peripheral #(
  parameter int unsigned DIV_RESET = 16,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  localparam logic [DIV_WIDTH-1:0] DivOne   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DivReset = DIV_WIDTH'(DIV_RESET);

  state_e               state_q, state_d;
  logic                 en_q, en_d;
  logic                 im_q, im_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [7:0]           txdata_q, txdata_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;
  logic [7:0]           shift_q, shift_d;
  logic [DIV_WIDTH-1:0] fdiv_q, fdiv_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;

  logic wr_ctrl, wr_div, wr_txdata, wr_status;
  logic bit_end, take, done_set;
  logic unused_bits;

  assign wr_ctrl   = WE && (Addr[3:2] == 2'd0);
  assign wr_div    = WE && (Addr[3:2] == 2'd1);
  assign wr_txdata = WE && (Addr[3:2] == 2'd2);
  assign wr_status = WE && (Addr[3:2] == 2'd3);

  // fdiv_q is never 0 outside IDLE, so this marks the last cycle of the current bit.
  assign bit_end = (cnt_q == (fdiv_q - DivOne));

  assign unused_bits = ^{Addr[31:4], Din};

  always_comb begin
    // NOTE: every combinational output gets its default first so no path can infer a latch.
    state_d     = state_q;
    en_d        = en_q;
    im_d        = im_q;
    div_d       = div_q;
    txdata_d    = txdata_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = done_q;
    ovr_d       = ovr_q;
    shift_d     = shift_q;
    fdiv_d      = fdiv_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    take        = 1'b0;
    done_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        take = en_q && hold_full_q;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + DivOne;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + DivOne;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          done_set = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
          take     = en_q && hold_full_q;
        end else begin
          cnt_d = cnt_q + DivOne;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading the shifter also covers the back-to-back STOP -> START case.
    if (take) begin
      state_d     = S_START;
      shift_d     = hold_q;
      fdiv_d      = (div_q == '0) ? DivOne : div_q;
      cnt_d       = '0;
      bit_d       = 3'd0;
      hold_full_d = 1'b0;
    end

    if (wr_ctrl) begin
      en_d = Din[0];
      im_d = Din[1];
    end
    if (wr_div) begin
      div_d = Din[DIV_WIDTH-1:0];
    end
    if (wr_txdata) begin
      txdata_d = Din[7:0];
      if (!hold_full_q || take) begin
        hold_d      = Din[7:0];
        hold_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (wr_status) begin
      if (Din[2]) done_d = 1'b0;
      if (Din[3]) ovr_d = 1'b0;
    end
    // A frame completing on the same edge as a clear-write keeps the flag set.
    if (done_set) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b0;
      im_q        <= 1'b0;
      div_q       <= DivReset;
      txdata_q    <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      shift_q     <= 8'h00;
      fdiv_q      <= DivOne;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q     <= state_d;
      en_q        <= en_d;
      im_q        <= im_d;
      div_q       <= div_d;
      txdata_q    <= txdata_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      shift_q     <= shift_d;
      fdiv_q      <= fdiv_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
    end
  end

  always_comb begin
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign IRQ = done_q & im_q;

  always_comb begin
    case (Addr[3:2])
      2'd0:    Dout = {30'd0, im_q, en_q};
      2'd1:    Dout = 32'(div_q);
      2'd2:    Dout = {24'd0, txdata_q};
      default: Dout = {28'd0, ovr_q, done_q, hold_full_q, (state_q != S_IDLE)};
    endcase
  end

endmodule
